// File: rtl/blk_pix_fetch.sv
// Block index to pixel-address sweeper feeding the frame-buffer read port.
// Define BLK_PIX_FETCH_LAST_EN to add o_rd_last on the final pixel of a block.
`timescale 1ns/1ps
module blk_pix_fetch #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int BLK_SIZE   = 32,
   parameter int COLUMNS    = IMG_WIDTH / BLK_SIZE,
   parameter int ROWS       = IMG_HEIGHT / BLK_SIZE,
   parameter int BADR_W     = $clog2(COLUMNS * ROWS),
   parameter int PADR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_blk_vld,
   input  logic [BADR_W-1:0] i_blk_adr,
   output logic              o_blk_rdy,
   input  logic              i_blk_eof,
   output logic              o_rd_vld,
   output logic [PADR_W-1:0] o_rd_adr,
   input  logic              i_rd_rdy,
`ifdef BLK_PIX_FETCH_LAST_EN
   output logic              o_rd_last,
`endif
   output logic              o_blk_done,
   output logic              o_frm_done,
   output logic              o_err
);

   localparam int PW = $clog2(BLK_SIZE);
   localparam logic [PW-1:0] PMAX = PW'(BLK_SIZE - 1);
   localparam logic [BADR_W:0] NBLK = (BADR_W + 1)'(COLUMNS * ROWS);
   localparam logic [PADR_W-1:0] ROW_STEP = PADR_W'(IMG_WIDTH);
   localparam logic [PADR_W-1:0] ROW_BLK = PADR_W'(BLK_SIZE * IMG_WIDTH);
   localparam logic [PADR_W-1:0] COL_BLK = PADR_W'(BLK_SIZE);

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      SWEEP,
      DONE
   } state_t;

   state_t            state;
   logic [BADR_W-1:0] adr_q;
   logic [PADR_W-1:0] base;
   logic [PW-1:0]     px;
   logic [PW-1:0]     py;
   logic              eof_pend;

   logic [BADR_W-1:0] brow;
   logic [BADR_W-1:0] bcol;
   logic [PADR_W-1:0] base_c;
   logic [PW-1:0]     npx;
   logic [PW-1:0]     npy;
   logic [PADR_W-1:0] nadr;
   logic              in_range;
   logic              hs;
   logic              px_wrap;
   logic              at_last;

   assign in_range = {1'b0, i_blk_adr} < NBLK;
   assign hs       = o_rd_vld & i_rd_rdy;
   assign px_wrap  = px == PMAX;
   assign at_last  = px_wrap & (py == PMAX);

   // Constant divisor; synthesises to a small fixed-ratio divider.
   always_comb begin
      brow   = adr_q / BADR_W'(COLUMNS);
      bcol   = adr_q % BADR_W'(COLUMNS);
      base_c = PADR_W'(brow) * ROW_BLK + PADR_W'(bcol) * COL_BLK;
   end

   always_comb begin
      npx  = px_wrap ? '0 : px + PW'(1);
      npy  = px_wrap ? py + PW'(1) : py;
      nadr = base + PADR_W'(npy) * ROW_STEP + PADR_W'(npx);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         adr_q      <= '0;
         base       <= '0;
         px         <= '0;
         py         <= '0;
         eof_pend   <= 1'b0;
         o_blk_rdy  <= 1'b1;
         o_rd_vld   <= 1'b0;
         o_rd_adr   <= '0;
         o_blk_done <= 1'b0;
         o_frm_done <= 1'b0;
         o_err      <= 1'b0;
`ifdef BLK_PIX_FETCH_LAST_EN
         o_rd_last  <= 1'b0;
`endif
      end else begin
         o_blk_done <= 1'b0;
         o_frm_done <= 1'b0;
         o_err      <= 1'b0;
         eof_pend   <= eof_pend | i_blk_eof;
         unique case (state)
            IDLE: begin
               if (i_blk_vld && in_range) begin
                  adr_q     <= i_blk_adr;
                  o_blk_rdy <= 1'b0;
                  state     <= DECODE;
               end else begin
                  o_err <= i_blk_vld;
                  // Nothing in flight: the frame ends right here.
                  if (eof_pend | i_blk_eof) begin
                     o_frm_done <= 1'b1;
                     eof_pend   <= 1'b0;
                  end
               end
            end
            DECODE: begin
               base     <= base_c;
               px       <= '0;
               py       <= '0;
               o_rd_vld <= 1'b1;
               o_rd_adr <= base_c;
`ifdef BLK_PIX_FETCH_LAST_EN
               o_rd_last <= PMAX == '0;
`endif
               state    <= SWEEP;
            end
            SWEEP: begin
               if (hs) begin
                  if (at_last) begin
                     o_rd_vld   <= 1'b0;
                     o_blk_done <= 1'b1;
                     o_frm_done <= eof_pend | i_blk_eof;
                     eof_pend   <= 1'b0;
`ifdef BLK_PIX_FETCH_LAST_EN
                     o_rd_last  <= 1'b0;
`endif
                     state      <= DONE;
                  end else begin
                     px       <= npx;
                     py       <= npy;
                     o_rd_adr <= nadr;
`ifdef BLK_PIX_FETCH_LAST_EN
                     o_rd_last <= (npx == PMAX) && (npy == PMAX);
`endif
                  end
               end
            end
            DONE: begin
               o_blk_rdy <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blk_pix_fetch.sv
// Directed bench for blk_pix_fetch: sweeps, range errors, eof and reset.
`timescale 1ns/1ps
module tb_blk_pix_fetch;

   logic        clk;
   logic        rst_n;
   logic        i_blk_vld;
   logic [8:0]  i_blk_adr;
   logic        o_blk_rdy;
   logic        i_blk_eof;
   logic        o_rd_vld;
   logic [18:0] o_rd_adr;
   logic        i_rd_rdy;
   logic        o_blk_done;
   logic        o_frm_done;
   logic        o_err;
`ifdef BLK_PIX_FETCH_LAST_EN
   logic        o_rd_last;
`endif

   int n_chk;
   int n_fail;

   blk_pix_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_blk_vld  (i_blk_vld),
      .i_blk_adr  (i_blk_adr),
      .o_blk_rdy  (o_blk_rdy),
      .i_blk_eof  (i_blk_eof),
      .o_rd_vld   (o_rd_vld),
      .o_rd_adr   (o_rd_adr),
      .i_rd_rdy   (i_rd_rdy),
`ifdef BLK_PIX_FETCH_LAST_EN
      .o_rd_last  (o_rd_last),
`endif
      .o_blk_done (o_blk_done),
      .o_frm_done (o_frm_done),
      .o_err      (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // eof_k: -1 none, -2 with the index, >=0 during sweep at pixel k.
   // abort_k >= 0 stops after that many handshakes.
   task automatic run_block(input int idx, input int base, input int last,
                            input bit rnd, input int eof_k,
                            input int abort_k);
      int  k;
      int  cyc;
      int  exp_adr;
      int  last_seen;
      bit  exp_frm;
      bit  eof_sent;
      k = 0;
      cyc = 0;
      last_seen = -1;
      eof_sent = 1'b0;
      exp_frm = (eof_k == -2);
      chk("rdy_idle", o_blk_rdy, 1);
      i_blk_vld = 1'b1;
      i_blk_adr = idx[8:0];
      i_blk_eof = (eof_k == -2);
      i_rd_rdy  = 1'b0;
      tick();
      i_blk_vld = 1'b0;
      i_blk_eof = 1'b0;
      chk("rdy_low", o_blk_rdy, 0);
      chk("decode_novld", o_rd_vld, 0);
      chk("no_frm_early", o_frm_done, 0);
      tick();
      chk("first_vld", o_rd_vld, 1);
      chk("first_adr", o_rd_adr, base);
      while (k < 1024 && cyc < 8000 && k != abort_k) begin
         i_rd_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (eof_k >= 0 && k == eof_k && !eof_sent) begin
            i_blk_eof = 1'b1;
            eof_sent  = 1'b1;
            exp_frm   = 1'b1;
         end else begin
            i_blk_eof = 1'b0;
         end
         exp_adr = base + (k / 32) * 640 + (k % 32);
         chk("pix_vld", o_rd_vld, 1);
         chk("pix_adr", o_rd_adr, exp_adr);
         chk("no_done_mid", o_blk_done, 0);
`ifdef BLK_PIX_FETCH_LAST_EN
         chk("rd_last", o_rd_last, k == 1023);
`endif
         if (i_rd_rdy) begin
            last_seen = exp_adr;
            k++;
         end
         tick();
         cyc++;
      end
      i_rd_rdy  = 1'b0;
      i_blk_eof = 1'b0;
      if (abort_k < 0) begin
         chk("hs_count", k, 1024);
         chk("last_adr", last_seen, last);
         chk("done_vld0", o_rd_vld, 0);
         chk("blk_done", o_blk_done, 1);
         chk("frm_done", o_frm_done, exp_frm);
         tick();
         chk("done_clr", o_blk_done, 0);
         chk("frm_clr", o_frm_done, 0);
         chk("rdy_back", o_blk_rdy, 1);
      end
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      i_blk_vld = 1'b0;
      i_blk_adr = '0;
      i_blk_eof = 1'b0;
      i_rd_rdy  = 1'b0;
      tick();
      tick();
      chk("rst_rdy", o_blk_rdy, 1);
      chk("rst_vld", o_rd_vld, 0);
      chk("rst_adr", o_rd_adr, 0);
      chk("rst_done", o_blk_done, 0);
      chk("rst_frm", o_frm_done, 0);
      chk("rst_err", o_err, 0);
      rst_n = 1'b1;
      tick();

      run_block(0, 0, 19871, 1'b0, -1, -1);
      run_block(21, 20512, 40383, 1'b0, -2, -1);
      run_block(299, 287328, 307199, 1'b0, -1, -1);

      i_blk_vld = 1'b1;
      i_blk_adr = 9'd300;
      tick();
      i_blk_vld = 1'b0;
      chk("err_pulse", o_err, 1);
      chk("err_rdy", o_blk_rdy, 1);
      chk("err_novld", o_rd_vld, 0);
      tick();
      chk("err_clr", o_err, 0);
      chk("err_novld2", o_rd_vld, 0);
      tick();
      chk("err_novld3", o_rd_vld, 0);
      chk("err_rdy2", o_blk_rdy, 1);

      run_block(5, 160, 20031, 1'b1, -1, -1);
      run_block(7, 224, 20095, 1'b0, 500, -1);

      i_blk_eof = 1'b1;
      tick();
      i_blk_eof = 1'b0;
      chk("idle_eof_frm", o_frm_done, 1);
      chk("idle_eof_nodone", o_blk_done, 0);
      tick();
      chk("idle_eof_clr", o_frm_done, 0);

      run_block(0, 0, 19871, 1'b0, -1, 100);
      chk("pre_rst_adr", o_rd_adr, 100 / 32 * 640 + 100 % 32);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_vld", o_rd_vld, 0);
      chk("mid_rst_rdy", o_blk_rdy, 1);
      chk("mid_rst_done", o_blk_done, 0);
      chk("mid_rst_frm", o_frm_done, 0);
      tick();
      run_block(0, 0, 19871, 1'b0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/blk_pix_fetch.md
Name: blk_pix_fetch

Overview:
- Consumer end of the block-address stream produced by the team's block address generator.
- Accepts one block index at a time over a valid/ready handshake and converts it to a top-left pixel address.
- Sweeps all BLK_SIZE x BLK_SIZE pixel addresses of that block to a frame-memory read port, with backpressure.
- Reports block completion and end of frame, and sits between the address generator and the frame-buffer reader.

Parameters:
- IMG_WIDTH, 640, image width in pixels
- IMG_HEIGHT, 480, image height in pixels
- BLK_SIZE, 32, block edge in pixels (power of two)
- COLUMNS, IMG_WIDTH/BLK_SIZE, blocks per row (20)
- ROWS, IMG_HEIGHT/BLK_SIZE, block rows (15)
- BADR_W, $clog2(COLUMNS*ROWS), block index width (9)
- PADR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), pixel address width (19)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- i_blk_vld  in  1  block index valid
- i_blk_adr  in  BADR_W  block index, row-major: row*COLUMNS+col
- o_blk_rdy  out  1  ready to accept a block index
- i_blk_eof  in  1  one-cycle pulse: frame's index stream finished
- o_rd_vld  out  1  pixel read request valid
- o_rd_adr  out  PADR_W  pixel address, row-major: y*IMG_WIDTH+x
- i_rd_rdy  in  1  memory accepts request
- o_blk_done  out  1  one-cycle pulse: all pixels of block issued
- o_frm_done  out  1  one-cycle pulse: frame complete
- o_err  out  1  one-cycle pulse: out-of-range index dropped

Behaviour:
- Reset (clk edge with rst_n=0) forces all outputs and internal counters to 0, except o_blk_rdy=1; state=IDLE; eof_pend=0. Reset overrides any activity, including mid-sweep.
- States: IDLE, DECODE, SWEEP, DONE.
- IDLE:
  - o_blk_rdy=1.
  - On i_blk_vld=1 with i_blk_adr >= COLUMNS*ROWS: o_err=1 next cycle for 1 cycle, index dropped, stay IDLE.
  - On a valid index: latch it, o_blk_rdy=0 next cycle, go to DECODE.
- DECODE (1 cycle):
  - base = (adr/COLUMNS)*BLK_SIZE*IMG_WIDTH + (adr%COLUMNS)*BLK_SIZE, registered.
  - px=py=0; go to SWEEP.
- SWEEP:
  - o_rd_vld=1, o_rd_adr = base + py*IMG_WIDTH + px.
  - On o_rd_vld&&i_rd_rdy: px increments; at px=BLK_SIZE-1, px wraps to 0 and py increments.
  - When the handshake occurs at px=py=BLK_SIZE-1: go to DONE, and o_rd_vld=0 next cycle.
  - While i_rd_rdy=0, o_rd_adr and o_rd_vld hold stable. No skipped or duplicated addresses.
- DONE (1 cycle):
  - o_blk_done=1.
  - If eof_pend=1: o_frm_done=1 in the same cycle, and eof_pend clears.
  - Go to IDLE.
- Latency: index accepted at cycle T -> first o_rd_vld at T+2 -> o_blk_done at cycle after last handshake.
- Minimum block period with i_rd_rdy held 1: BLK_SIZE^2+3 cycles.
- i_blk_eof:
  - Sets eof_pend in any state.
  - If it arrives in IDLE with no block in flight: o_frm_done pulses the next cycle and eof_pend clears.
  - If i_blk_eof and a valid index arrive in the same IDLE cycle: the block is accepted, and the frame-done is deferred to that block's DONE.
- Arithmetic: all address math at PADR_W bits; no wrap is possible for in-range indices (max 307199).
- i_blk_vld is ignored whenever o_blk_rdy=0. The producer must hold the index until accepted.

Optional Feature:
- Macro: BLK_PIX_FETCH_LAST_EN.
- Defined: adds output port o_rd_last (1 bit), which is 1 together with o_rd_vld only for pixel px=py=BLK_SIZE-1, held stable under backpressure, and reset to 0.
- Undefined: port absent; all other behaviour is identical.

Test Plan:
- Index 0, i_rd_rdy=1:
  - Reads 0..31, 640..671, ..., last 19871; exactly 1024 handshakes.
  - o_blk_done one cycle after the last handshake; first read 2 cycles after accept.
- Index 21 -> base 20512, last address 40383.
- Index 299 -> base 287328, last address 307199.
- Index 300 -> o_err pulse, zero reads, o_blk_rdy stays 1.
- Index 5 with i_rd_rdy pseudo-random (~50%):
  - o_rd_adr stable while stalled.
  - Captured sequence equals the stall-free sequence; 1024 handshakes.
- Index 7 with i_blk_eof pulsed during SWEEP:
  - o_frm_done coincides with o_blk_done.
  - A second i_blk_eof in IDLE gives o_frm_done the next cycle.
- Reset after 100 handshakes:
  - Next cycle o_rd_vld=0, o_blk_rdy=1, no done pulses.
  - A following index 0 sweeps from address 0.
